// File: rtl/bus_controller.sv
// bus_controller: Moore-decoded control FSM that sequences mv/mvi/add/sub/sin/cos
// over a shared bus, driving register, ALU and CORDIC selects and enables.
module bus_controller (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [31:0] DIN,
  input  logic        CordicDone,
  output logic [31:0] Rout,
  output logic        Gout,
  output logic        DINout,
  output logic        Sinout,
  output logic        Cosout,
  output logic [31:0] Rin,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        CordicStart,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic [2:0] {IDLE, T1, T2, T3, WAIT} state_t;
  state_t      r_state, w_next;
  logic [13:0] r_ir;
  logic [3:0]  w_op;
  logic [31:0] w_xsel, w_ysel;
  logic        w_unused;
  assign w_unused = ^DIN[17:0];
  assign w_op   = r_ir[13:10];
  assign w_xsel = 32'h1 << r_ir[9:5];
  assign w_ysel = 32'h1 << r_ir[4:0];
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      r_state <= IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && Run) r_ir <= DIN[31:18];
    end
  always_comb begin
    w_next      = r_state;
    Rout        = '0;
    Rin         = '0;
    Gout        = 1'b0;
    DINout      = 1'b0;
    Sinout      = 1'b0;
    Cosout      = 1'b0;
    Ain         = 1'b0;
    Gin         = 1'b0;
    AddSub      = 1'b0;
    CordicStart = 1'b0;
    Done        = 1'b0;
    Busy        = r_state != IDLE;
    case (r_state)
      IDLE: w_next = Run ? T1 : IDLE;
      T1: begin
        w_next = IDLE;
        case (w_op)
          4'd0: begin
            Rout = w_ysel;
            Rin  = w_xsel;
            Done = 1'b1;
          end
          4'd1: begin
            DINout = 1'b1;
            Rin    = w_xsel;
            Done   = 1'b1;
          end
          4'd2, 4'd3: begin
            Rout   = w_xsel;
            Ain    = 1'b1;
            w_next = T2;
          end
          4'd4, 4'd5: begin
            Rout        = w_ysel;
            CordicStart = 1'b1;
            w_next      = WAIT;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        Rout   = w_ysel;
        Gin    = 1'b1;
        AddSub = w_op == 4'd3;
        w_next = T3;
      end
      WAIT: w_next = CordicDone ? T3 : WAIT;
      T3: begin
        Gout   = w_op == 4'd2 || w_op == 4'd3;
        Sinout = w_op == 4'd4;
        Cosout = w_op == 4'd5;
        Rin    = w_xsel;
        Done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bus_controller.sv
// tb_bus_controller: directed and random instruction streams checked cycle by cycle
// against an instruction-level model of the expected control outputs.
module tb_bus_controller;
  logic        Clock = 1'b0, Reset = 1'b1, Run = 1'b0, CordicDone = 1'b0;
  logic [31:0] DIN = '0;
  logic [31:0] Rout, Rin;
  logic        Gout, DINout, Sinout, Cosout, Ain, Gin, AddSub, CordicStart, Busy, Done;
  typedef struct packed {
    logic [31:0] rout, rin;
    logic gout, dinout, sinout, cosout, ain, gin, addsub, cstart, busy, done;
  } out_t;
  localparam out_t Z = '0;
  out_t exp_q[$];
  logic cd_q[$];
  int   errors = 0, checks = 0;
  bus_controller dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .DIN(DIN), .CordicDone(CordicDone),
    .Rout(Rout), .Gout(Gout), .DINout(DINout), .Sinout(Sinout), .Cosout(Cosout),
    .Rin(Rin), .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .CordicStart(CordicStart),
    .Busy(Busy), .Done(Done)
  );
  always #5 Clock = ~Clock;
  task automatic check(input out_t e, input string tag);
    out_t got;
    got = {Rout, Rin, Gout, DINout, Sinout, Cosout, Ain, Gin, AddSub, CordicStart, Busy, Done};
    if (!e.gin) got.addsub = e.addsub;
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s outputs got=%h exp=%h", tag, got, e);
    end
    checks++;
    assert (($countones({Rout, Gout, DINout, Sinout, Cosout}) <= 1) === 1'b1) else begin
      errors++;
      $error("FAIL %s bus_onehot got=%h exp=at most one select", tag, {Rout, Gout, DINout, Sinout, Cosout});
    end
    checks++;
    assert (($countones(Rin) <= 1) === 1'b1) else begin
      errors++;
      $error("FAIL %s rin_onehot got=%h exp=at most one bit", tag, Rin);
    end
  endtask
  task automatic step(input out_t e, input string tag);
    @(negedge Clock);
    check(e, tag);
    @(posedge Clock);
    #1;
  endtask
  function automatic void build(input logic [31:0] ins, input int nw);
    out_t        e;
    logic [3:0]  op = ins[31:28];
    logic [31:0] xs = 32'h1 << ins[27:23];
    logic [31:0] ys = 32'h1 << ins[22:18];
    exp_q.delete();
    cd_q.delete();
    e = Z;
    e.busy = 1'b1;
    if (op == 4'd0) begin
      e.rout = ys; e.rin = xs; e.done = 1'b1;
      exp_q.push_back(e); cd_q.push_back(1'($urandom));
    end else if (op == 4'd1) begin
      e.dinout = 1'b1; e.rin = xs; e.done = 1'b1;
      exp_q.push_back(e); cd_q.push_back(1'($urandom));
    end else if (op == 4'd2 || op == 4'd3) begin
      e.rout = xs; e.ain = 1'b1;
      exp_q.push_back(e); cd_q.push_back(1'($urandom));
      e = Z; e.busy = 1'b1; e.rout = ys; e.gin = 1'b1; e.addsub = op == 4'd3;
      exp_q.push_back(e); cd_q.push_back(1'($urandom));
      e = Z; e.busy = 1'b1; e.gout = 1'b1; e.rin = xs; e.done = 1'b1;
      exp_q.push_back(e); cd_q.push_back(1'($urandom));
    end else if (op == 4'd4 || op == 4'd5) begin
      e.rout = ys; e.cstart = 1'b1;
      exp_q.push_back(e); cd_q.push_back(1'($urandom));
      e = Z; e.busy = 1'b1;
      for (int i = 0; i < nw; i++) begin
        exp_q.push_back(e); cd_q.push_back(1'b0);
      end
      exp_q.push_back(e); cd_q.push_back(1'b1);
      e.sinout = op == 4'd4; e.cosout = op == 4'd5; e.rin = xs; e.done = 1'b1;
      exp_q.push_back(e); cd_q.push_back(1'($urandom));
    end else begin
      e.done = 1'b1;
      exp_q.push_back(e); cd_q.push_back(1'($urandom));
    end
  endfunction
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] imm, input int nw,
                           input bit hold, input string tag);
    build(ins, nw);
    Run = 1'b1; DIN = ins; CordicDone = 1'($urandom);
    step(Z, {tag, " fetch"});
    DIN = imm;
    foreach (exp_q[i]) begin
      Run = hold ? 1'b1 : 1'($urandom);
      CordicDone = cd_q[i];
      step(exp_q[i], $sformatf("%s c%0d", tag, i));
    end
    Run = 1'b0; CordicDone = 1'b0;
  endtask
  initial begin
    logic [31:0] ins;
    logic [3:0]  op;
    #2;
    check(Z, "reset");
    Run = 1'b1; DIN = 32'h1080_0000;
    step(Z, "reset run");
    Run = 1'b0;
    Reset = 1'b0;
    step(Z, "idle");
    run_instr(32'h1080_0000, 32'h0000_00AB, 0, 0, "mvi");
    step(Z, "mvi idle");
    run_instr(32'h2110_0000, 32'h0, 0, 0, "add");
    run_instr(32'h3110_0000, 32'h0, 0, 0, "sub");
    run_instr(32'h218C_0000, 32'h0, 0, 0, "add33");
    step(Z, "idle2");
    run_instr(32'h5F84_0000, 32'h0, 7, 0, "cos");
    run_instr(32'h4194_0000, 32'h0, 0, 0, "sin");
    run_instr(32'hF000_0000, 32'h0, 0, 0, "ill");
    run_instr(32'h2110_0000, 32'h0, 0, 1, "addhold");
    run_instr(32'h0014_0000, 32'h0, 0, 0, "mvnext");
    step(Z, "idle3");
    build(32'h4194_0000, 100);
    Run = 1'b1; DIN = 32'h4194_0000;
    step(Z, "rw fetch");
    Run = 1'b0; CordicDone = 1'b0;
    step(exp_q[0], "rw t1");
    step(exp_q[1], "rw wait");
    Reset = 1'b1; CordicDone = 1'b1;
    #1;
    check(Z, "rw async");
    step(Z, "rw hold1");
    step(Z, "rw hold2");
    Reset = 1'b0; CordicDone = 1'b0;
    run_instr(32'h0014_0000, 32'h0, 0, 0, "rw mv");
    step(Z, "idle4");
    for (int n = 0; n < 60; n++) begin
      op  = ($urandom % 4 == 0) ? 4'(6 + $urandom % 10) : 4'($urandom % 6);
      ins = {op, 28'($urandom)};
      run_instr(ins, $urandom, int'($urandom % 6), 1'($urandom), $sformatf("rnd%0d", n));
      if ($urandom % 2 == 1) step(Z, $sformatf("rnd%0d idle", n));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
